// File: rtl/uart_sync_tx.sv
// 8N1 UART transmitter with a small byte FIFO and automatic calibration-byte
// insertion ahead of data, for driving an autobaud receiver.
module uart_sync_tx #(
  parameter int         DIV_W      = 16,
  parameter logic [7:0] SYNC_BYTE  = 8'h55,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             sync_req,
  input  logic             transmit,
  input  logic [7:0]       data_tx,
  output logic             full,
  output logic             busy_tx,
  output logic             sync_done,
  output logic             tx
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           r_state, w_state_nx;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count, w_count_nx;
  logic [7:0]       r_byte;
  logic             r_is_sync, r_sync_pending, r_tx, r_busy;
  logic [DIV_W-1:0] r_period, r_bcnt, w_div_eff;
  logic [2:0]       r_idx, w_idx_inc;
  logic             w_push, w_pop, w_load, w_bit_end, w_sync_clear, w_frame_sync, w_tx_nx;

  assign full         = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push       = transmit && !full;
  assign w_bit_end    = (r_bcnt == r_period - DIV_W'(1));
  assign w_sync_clear = (r_state == S_STOP) && w_bit_end && r_is_sync;
  // A sync frame that is just finishing no longer counts as pending for the frame loaded behind it.
  assign w_frame_sync = r_sync_pending && !w_sync_clear;
  assign w_pop        = w_load && !w_frame_sync;
  assign w_count_nx   = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_div_eff    = (div < DIV_W'(2)) ? DIV_W'(2) : div;
  assign w_idx_inc    = r_idx + 3'd1;

  assign sync_done = w_sync_clear;
  assign tx        = r_tx;
  assign busy_tx   = r_busy;

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_tx_nx    = r_tx;
    case (r_state)
      S_IDLE: begin
        w_tx_nx = 1'b1;
        if (r_count != '0) begin
          w_load     = 1'b1;
          w_state_nx = S_START;
          w_tx_nx    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nx = S_DATA;
          w_tx_nx    = r_byte[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_idx == 3'd7) begin
            w_state_nx = S_STOP;
            w_tx_nx    = 1'b1;
          end else begin
            w_tx_nx = r_byte[w_idx_inc];
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_count != '0) begin
            w_load     = 1'b1;
            w_state_nx = S_START;
            w_tx_nx    = 1'b0;
          end else begin
            w_state_nx = S_IDLE;
            w_tx_nx    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_tx_nx    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_sync_pending <= 1'b1;
      r_is_sync      <= 1'b0;
      r_period       <= '0;
      r_bcnt         <= '0;
      r_idx          <= '0;
      r_tx           <= 1'b1;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_count        <= w_count_nx;
      r_tx           <= w_tx_nx;
      r_busy         <= (w_state_nx != S_IDLE) || (w_count_nx != '0);
      r_sync_pending <= sync_req || (r_sync_pending && !w_sync_clear);
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      if (w_load) begin
        r_is_sync <= w_frame_sync;
        r_period  <= w_div_eff;
      end
      if (w_load || w_bit_end || r_state == S_IDLE) r_bcnt <= '0;
      else                                          r_bcnt <= r_bcnt + DIV_W'(1);
      if (r_state == S_START && w_bit_end)     r_idx <= '0;
      else if (r_state == S_DATA && w_bit_end) r_idx <= w_idx_inc;
    end
  end

  // FIFO storage and the frame shift byte hold no control state, so they are not reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= data_tx;
    if (w_load) r_byte <= w_frame_sync ? SYNC_BYTE : r_mem[r_rptr];
  end

endmodule

// File: tb/tb_uart_sync_tx.sv
// Randomised and directed bench for uart_sync_tx: a line-level reference model
// queues expected frames, and a monitor decodes tx and scores each frame.
module tb_uart_sync_tx;

  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, sync_req, transmit;
  logic [15:0] div;
  logic [7:0]  data_tx;
  logic        full, busy_tx, sync_done, tx;

  uart_sync_tx #(.DIV_W(16), .SYNC_BYTE(8'h55), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .div(div), .sync_req(sync_req), .transmit(transmit),
    .data_tx(data_tx), .full(full), .busy_tx(busy_tx), .sync_done(sync_done), .tx(tx)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; bit s; } fr_t;
  fr_t exp_q[$];
  bit  m_sync;
  int  n_checks = 0, n_errors = 0;
  int  mon_phase = -1, mon_p = 2;
  bit  mon_cur_sync = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int model_cnt();
    int c = 0;
    foreach (exp_q[i]) if (!exp_q[i].s) c++;
    return c;
  endfunction

  // Reference model: a byte is accepted when fewer than FIFO_DEPTH data bytes wait;
  // a pending calibration frame is placed directly ahead of the next data byte.
  task automatic push(input logic [7:0] b);
    transmit = 1'b1; data_tx = b;
    if (model_cnt() < FIFO_DEPTH) begin
      if (m_sync) begin exp_q.push_back('{8'h55, 1'b1}); m_sync = 1'b0; end
      exp_q.push_back('{b, 1'b0});
    end
    @(posedge clk); #1;
    transmit = 1'b0;
  endtask

  task automatic pulse_sync();
    sync_req = 1'b1;
    if (mon_phase >= 0 && mon_cur_sync) begin
      // a calibration frame already in flight absorbs the request
    end else if (exp_q.size() > 0) begin
      if (!exp_q[0].s) exp_q.push_front('{8'h55, 1'b1});
    end else begin
      m_sync = 1'b1;
    end
    @(posedge clk); #1;
    sync_req = 1'b0;
  endtask

  function automatic bit in_window();
    return (mon_phase >= 1) && (mon_phase <= 10 * mon_p - 3);
  endfunction

  task automatic wait_phase(input int min_phase);
    int k = 0;
    while (!(mon_phase >= min_phase && in_window()) && k < 20000) begin
      @(posedge clk); #1; k++;
    end
    chk("wait_phase_timeout", (k < 20000), 1);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || mon_phase >= 0 || busy_tx) && k < budget) begin
      @(posedge clk); #1; k++;
    end
    chk("drain_timeout", (k < budget), 1);
  endtask

  task automatic run_frame(output bit gap_next);
    fr_t        cur;
    int         p, snap, bi;
    logic [7:0] got;
    bit         wave_ok, sd_ok, aborted, unexpected;
    logic       eb, sde;
    gap_next = 1'b0; unexpected = 1'b0; aborted = 1'b0;
    wave_ok = 1'b1; sd_ok = 1'b1; got = 8'h00; snap = 0;
    p = (div < 16'd2) ? 2 : int'(div);
    mon_p = p;
    if (exp_q.size() == 0) begin
      unexpected = 1'b1;
      cur = '{8'h00, 1'b0};
      n_checks++; n_errors++;
      $display("FAIL unexpected_frame: start bit seen with nothing queued, required idle line (t=%0t)", $time);
    end else begin
      cur = exp_q.pop_front();
    end
    mon_cur_sync = cur.s;
    for (int i = 0; i < 10 * p; i++) begin
      if (i > 0) @(negedge clk);
      if (rst) begin aborted = 1'b1; break; end
      mon_phase = i;
      bi = i / p;
      eb = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : cur.b[bi-1];
      if (tx !== eb) wave_ok = 1'b0;
      if ((i % p) == p / 2 && bi >= 1 && bi <= 8) got[bi-1] = tx;
      sde = cur.s && (i == 10 * p - 1);
      if (sync_done !== sde) sd_ok = 1'b0;
      if (i == 10 * p - 2) snap = exp_q.size();
    end
    mon_phase = -1;
    if (!aborted && !unexpected) begin
      chk("frame_byte", got, cur.b);
      chk("frame_wave", wave_ok, 1);
      chk("sync_done_pulse", sd_ok, 1);
      gap_next = (snap > 0);
    end
  endtask

  initial begin : monitor
    bit need_start;
    need_start = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        need_start = 1'b0; mon_phase = -1;
      end else begin
        if (need_start) begin
          chk("no_gap", tx, 0);
          need_start = 1'b0;
        end
        if (tx === 1'b0) run_frame(need_start);
        else if (sync_done !== 1'b0) chk("sync_done_idle", sync_done, 0);
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int r;
    rst = 1'b1; sync_req = 1'b0; transmit = 1'b0; data_tx = 8'h00; div = 16'd434;
    m_sync = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_tx", tx, 1);
    chk("post_reset_busy", busy_tx, 0);
    chk("post_reset_full", full, 0);

    // Asynchronous reset in the middle of a frame
    push(8'h77);
    repeat (100) @(posedge clk);
    chk("busy_in_frame", busy_tx, 1);
    chk("tx_low_in_start", tx, 0);
    #1 rst = 1'b1;
    exp_q.delete(); m_sync = 1'b1;
    #1;
    chk("async_reset_tx", tx, 1);
    chk("async_reset_full", full, 0);
    chk("async_reset_busy", busy_tx, 0);
    chk("async_reset_sync_done", sync_done, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // First data after reset gets a calibration frame, then back-to-back data
    push(8'hA5);
    repeat (8680) @(posedge clk);
    #1 chk("busy_before_end", busy_tx, 1);
    @(posedge clk); #1;
    chk("busy_after_two_frames", busy_tx, 0);
    drain(20000);

    // Idle latency and FIFO full/drop while a frame is in flight
    div = 16'd50;
    push(8'hF0);
    chk("latency_before_edge", tx, 1);
    @(posedge clk); #1;
    chk("latency_tx_fall", tx, 0);
    repeat (5) @(posedge clk);
    #1;
    push(8'h01); push(8'h02); push(8'h03);
    chk("full_after_3", full, 0);
    push(8'h04);
    chk("full_after_4", full, 1);
    push(8'h05);
    chk("full_after_drop", full, 1);
    drain(20000);

    // sync_req during DATA of 0x10 with 0x20 queued
    div = 16'd20;
    push(8'h10);
    wait_phase(40);
    push(8'h20);
    pulse_sync();
    drain(20000);

    // div change mid-frame, then degenerate divisors
    div = 16'd434;
    push(8'h3A);
    wait_phase(1000);
    div = 16'd100;
    push(8'hC3);
    drain(20000);
    div = 16'd0; push(8'h81); drain(2000);
    div = 16'd1; push(8'h7E); drain(2000);

    div = 16'd435; push(8'h3C); drain(20000);

    // Sync request while idle: line stays idle until data arrives
    div = 16'd8;
    pulse_sync();
    repeat (30) @(posedge clk);
    #1;
    chk("idle_sync_tx", tx, 1);
    chk("idle_sync_busy", busy_tx, 0);
    push(8'h99);
    drain(5000);

    // Randomised traffic
    div = 16'($urandom_range(2, 12));
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        if (model_cnt() < FIFO_DEPTH) push(8'($urandom_range(0, 255)));
        else begin @(posedge clk); #1; end
      end else if (r == 6) begin
        if (in_window()) pulse_sync();
        else begin @(posedge clk); #1; end
      end else if (r == 7) begin
        if (in_window()) div = 16'($urandom_range(0, 12));
        @(posedge clk); #1;
      end else begin
        repeat ($urandom_range(0, 30)) @(posedge clk);
        #1;
      end
    end
    drain(20000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_sync_tx.md
Name: uart_sync_tx

Overview:
Host-side UART transmitter that drives the rx line of the autobaud UART. It buffers bytes in a small FIFO and serialises them as 8N1 frames at a runtime-programmable bit period. Before the first data frame after reset, and whenever requested, it inserts a calibration byte so the far-end autobaud receiver can measure the bit period and lock. It is used both as bench stimulus and as the transmitter in host-facing designs.

Parameters:
DIV_W, 16, width of the bit-period divisor.
SYNC_BYTE, 8'h55, calibration byte sent ahead of data; its alternating bits give one-bit-period edges.
FIFO_DEPTH, 4, data FIFO entries; must be a power of 2, minimum 2.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  asynchronous, active-high reset.
div  input  DIV_W  bit period in clk cycles; 434 gives 115200 baud at 50 MHz.
sync_req  input  1  single-cycle pulse that arms insertion of SYNC_BYTE before the next data frame.
transmit  input  1  write strobe; pushes data_tx into the FIFO.
data_tx  input  8  byte to send.
full  output  1  FIFO holds FIFO_DEPTH entries.
busy_tx  output  1  a frame is in flight or the FIFO is non-empty.
sync_done  output  1  one-cycle pulse on the last cycle of the sync frame's stop bit.
tx  output  1  serial line; idles at 1.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - tx=1, full=0, busy_tx=0, sync_done=0.
  - FIFO is emptied, state=IDLE, all counters are 0.
  - sync_pending=1, so the first frame after reset is always SYNC_BYTE.
- FIFO:
  - transmit=1 with full=0 pushes data_tx on that edge.
  - transmit=1 with full=1 drops the byte; no state changes.
  - full is derived from the registered count. A push while full is dropped even if a pop happens on the same edge.
  - Pointers wrap modulo FIFO_DEPTH. The count ranges 0..FIFO_DEPTH.
- State machine: IDLE -> START -> DATA -> STOP -> IDLE or START.
  - IDLE:
    - tx=1.
    - If the FIFO is non-empty, latch the frame byte and go to START on the same edge. The frame byte is SYNC_BYTE if sync_pending=1; otherwise the FIFO head, which is popped.
    - If the FIFO is empty, stay in IDLE, even with sync_pending=1. A sync frame is only sent ahead of data.
  - START: tx=0 for one bit period.
  - DATA: 8 bits, LSB first, one bit period each. A 3-bit index counts 0..7.
  - STOP:
    - tx=1 for one bit period.
    - On the last cycle, if the frame was the sync frame: clear sync_pending and pulse sync_done.
    - On the same last cycle, if the FIFO is non-empty: load the next frame (sync or data) and go directly to START. There is no idle gap between frames.
    - Otherwise go to IDLE.
- Bit timing:
  - div is latched into a period register when a frame is loaded.
  - div<2 is treated as 2.
  - Each bit lasts exactly period cycles, so one frame is 10*period cycles.
  - Changing div mid-frame affects only later frames.
- Latency: with the block idle, no sync pending and a push at edge E, tx falls at edge E+1.
- sync_req:
  - Sets sync_pending on any cycle.
  - Mid-frame, the sync frame precedes the next data frame; the current frame is not affected.
  - If sync_req arrives on the same edge that a sync frame clears sync_pending, it re-arms sync_pending, and another sync frame follows.
- busy_tx = (state != IDLE) or (count != 0). It is registered and updates on the same edge as the state and count.
- tx is driven from a register, so it is glitch-free.

Test Plan:
1. Reset check: assert rst mid-operation -> tx=1, full=0, busy_tx=0, sync_done=0 immediately, before the next clock edge.
2. After reset, div=434, push 0xA5 -> a 0x55 frame (4340 cycles), sync_done high for exactly 1 cycle at its end, then 0xA5 with LSB first, no gap between frames; busy_tx=0 after 8680 cycles.
3. During a frame in flight, push 0x01..0x05 on consecutive cycles -> full=1 after the 4th push; 0x05 is dropped; the line carries 0x01..0x04 back-to-back; no sync frame is sent, since sync is already done.
4. Pulse sync_req in the DATA state of byte 0x10 while 0x20 is queued -> sequence on the line is 0x10, 0x55, 0x20.
5. Change div from 434 to 100 mid-frame -> the current frame keeps 434-cycle bits; the next frame uses 100-cycle bits; div=0 or 1 -> 2-cycle bits.
6. Loopback tx into uart_autobaud rx with div=435 (BAUD_PERIOD 8700 ns at 20 ns clk) and send 0x3C -> autobaud recieved asserts and data_rx=0x3C.
